scr1_vec_stream_mem: RTL



---
 rtl/scr1_vec_stream_mem_if.sv | 57 +++++
 rtl/scr1_vec_stream_mem.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/scr1_vec_stream_mem_if.sv
// ---------------------------------------------------------------------------
// scr1_vec_stream_mem_if
//   Bundles every non-clock signal of scr1_vec_stream_mem.
//   Handshake rule for both stream channels (s_*, r_*): a beat transfers on a
//   rising clk edge where valid and ready are both 1; the producer holds
//   valid and data stable until that edge, and ready may depend on anything.
//
//   Port A : rena, addra -> qa                 (scalar instruction read)
//   Port B : renb, wenb, webb, w_is_vector,
//            addrb, datab -> qb                (scalar / LANES-wide access)
//   Source : s_valid, s_data (memory -> accelerator), s_ready (back)
//   Result : r_valid, r_data (accelerator -> memory), r_ready (back)
//   Status : busy, done
//
//   modport master : the SoC/accelerator side of the memory
//   modport slave  : the memory itself
// ---------------------------------------------------------------------------
interface scr1_vec_stream_mem_if #(
    parameter int WIDTH = 32,
    parameter int LANES = 8,
    parameter int AW    = 14
);
    logic                   rena;
    logic [AW-1:0]          addra;
    logic [WIDTH-1:0]       qa;

    logic                   renb;
    logic                   wenb;
    logic [WIDTH/8-1:0]     webb;
    logic                   w_is_vector;
    logic [AW-1:0]          addrb;
    logic [LANES*WIDTH-1:0] datab;
    logic [LANES*WIDTH-1:0] qb;

    logic                   s_valid;
    logic                   s_ready;
    logic [LANES*WIDTH-1:0] s_data;

    logic                   r_valid;
    logic                   r_ready;
    logic [LANES*WIDTH-1:0] r_data;

    logic                   busy;
    logic                   done;

    modport master (
        output rena, addra, renb, wenb, webb, w_is_vector, addrb, datab,
               s_ready, r_valid, r_data,
        input  qa, qb, s_valid, s_data, r_ready, busy, done
    );

    modport slave (
        input  rena, addra, renb, wenb, webb, w_is_vector, addrb, datab,
               s_ready, r_valid, r_data,
        output qa, qb, s_valid, s_data, r_ready, busy, done
    );
endinterface

// File: rtl/scr1_vec_stream_mem.sv
// ---------------------------------------------------------------------------
// scr1_vec_stream_mem
//   Dual-port synchronous memory with a built-in stream engine.
//   Port A is a scalar read port; port B does scalar byte-enabled accesses or
//   LANES-word vector accesses (addresses wrap modulo RAM_WORDS). Writing the
//   all-ones word to DOORBELL_ADDR while idle launches a job: NBEATS beats of
//   LANES words are streamed from SRC_BASE on the s_* channel and the beats
//   returned on r_* are written to DST_BASE. At the end the doorbell word is
//   cleared and done pulses for one cycle.
//
//   Ports:
//     clk          clock
//     resetn       asynchronous active-low reset (RAM contents are kept)
//     bus          scr1_vec_stream_mem_if.slave (port A, port B, s_*, r_*,
//                  busy, done)
//     dbg_state_o  current engine state (IDLE=0, FEED=1, DRAIN=2, FIN=3)
//
//   Optional build macro SCR1_VEC_STREAM_TRACE_EN: prints every accepted
//   result beat (simulation only). Undefined by default.
// ---------------------------------------------------------------------------
module scr1_vec_stream_mem #(
    parameter int WIDTH         = 32,
    parameter int SIZE          = 65536,
    parameter int LANES         = 8,
    parameter int NBEATS        = 64,
    parameter int SRC_BASE      = 0,
    parameter int DST_BASE      = 1024,
    parameter int DOORBELL_ADDR = 512
) (
    input  logic                        clk,
    input  logic                        resetn,
    scr1_vec_stream_mem_if.slave        bus,
    output logic [1:0]                  dbg_state_o
);
    localparam int AW        = $clog2(SIZE) - 2;
    localparam int RAM_WORDS = SIZE / (WIDTH / 8);
    localparam int BYTES     = WIDTH / 8;
    localparam int CW        = $clog2(NBEATS) + 1;
    localparam int VW        = LANES * WIDTH;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FEED  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

    localparam logic [AW-1:0]    DB_A  = AW'(DOORBELL_ADDR);
    localparam logic [AW-1:0]    SRC_A = AW'(SRC_BASE);
    localparam logic [AW-1:0]    DST_A = AW'(DST_BASE);
    localparam logic [WIDTH-1:0] ONES  = {WIDTH{1'b1}};
    localparam logic [CW-1:0]    NB    = CW'(NBEATS);

    logic [WIDTH-1:0] mem_q [RAM_WORDS];

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    feed_cnt_q, feed_cnt_d;   // beats loaded into s_data
    logic [CW-1:0]    res_cnt_q, res_cnt_d;     // result beats written back
    logic             s_valid_q, s_valid_d;
    logic [VW-1:0]    s_data_q, s_data_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] qa_q;
    logic [VW-1:0]    qb_q;

    logic             start;
    logic             s_fire;
    logic             r_ready_int;
    logic             r_fire;
    logic             feed_load;
    logic             fin_write;
    logic [AW-1:0]    feed_addr;
    logic [AW-1:0]    res_addr;
    logic [VW-1:0]    feed_beat;

    // Doorbell: a scalar full-word write, or any vector lane landing on the
    // doorbell address, carrying all ones. Ignored unless idle.
    always_comb begin
        start = 1'b0;
        if (bus.wenb && (state_q == ST_IDLE)) begin
            if (!bus.w_is_vector) begin
                start = (bus.addrb == DB_A) && (&bus.webb) &&
                        (bus.datab[WIDTH-1:0] == ONES);
            end else begin
                for (int i = 0; i < LANES; i++) begin
                    if (((bus.addrb + AW'(i)) == DB_A) &&
                        (bus.datab[i*WIDTH +: WIDTH] == ONES)) begin
                        start = 1'b1;
                    end
                end
            end
        end
    end

    assign s_fire      = s_valid_q && bus.s_ready;
    // Port B owns the single write port, so results stall while it writes.
    assign r_ready_int = ((state_q == ST_FEED) || (state_q == ST_DRAIN)) &&
                         !bus.wenb && (res_cnt_q < NB);
    assign r_fire      = bus.r_valid && r_ready_int;
    // Refill the source register when it is empty or being emptied this edge.
    assign feed_load   = (state_q == ST_FEED) && (feed_cnt_q < NB) &&
                         (!s_valid_q || s_fire);
    assign fin_write   = (state_q == ST_FIN) && !bus.wenb;
    assign feed_addr   = SRC_A + AW'(feed_cnt_q) * AW'(LANES);
    assign res_addr    = DST_A + AW'(res_cnt_q) * AW'(LANES);

    always_comb begin
        feed_beat = '0;
        for (int i = 0; i < LANES; i++) begin
            feed_beat[i*WIDTH +: WIDTH] = mem_q[feed_addr + AW'(i)];
        end
    end

    always_comb begin
        state_d    = state_q;
        feed_cnt_d = feed_cnt_q;
        res_cnt_d  = res_cnt_q;
        s_valid_d  = s_valid_q;
        s_data_d   = s_data_q;
        done_d     = 1'b0;

        if (feed_load) begin
            s_data_d   = feed_beat;
            s_valid_d  = 1'b1;
            feed_cnt_d = feed_cnt_q + CW'(1);
        end else if (s_fire) begin
            s_valid_d  = 1'b0;
        end

        if (r_fire) begin
            res_cnt_d = res_cnt_q + CW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_FEED;
                    feed_cnt_d = '0;
                    res_cnt_d  = '0;
                end
            end
            ST_FEED: begin
                // Every beat has been loaded, so this acceptance is the last one.
                if (s_fire && (feed_cnt_q == NB)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (res_cnt_q == NB) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                if (!bus.wenb) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            feed_cnt_q <= '0;
            res_cnt_q  <= '0;
            s_valid_q  <= 1'b0;
            s_data_q   <= '0;
            done_q     <= 1'b0;
            qa_q       <= '0;
            qb_q       <= '0;
        end else begin
            state_q    <= state_d;
            feed_cnt_q <= feed_cnt_d;
            res_cnt_q  <= res_cnt_d;
            s_valid_q  <= s_valid_d;
            s_data_q   <= s_data_d;
            done_q     <= done_d;
            if (bus.rena) begin
                qa_q <= mem_q[bus.addra];
            end
            if (bus.renb) begin
                for (int i = 0; i < LANES; i++) begin
                    qb_q[i*WIDTH +: WIDTH] <= mem_q[bus.addrb + AW'(i)];
                end
            end
        end
    end

    // Single write port: port B first, then result beats, then the doorbell
    // clear (r_ready is low in FIN, so the last two never collide).
    always_ff @(posedge clk) begin
        if (bus.wenb) begin
            if (bus.w_is_vector) begin
                for (int i = 0; i < LANES; i++) begin
                    mem_q[bus.addrb + AW'(i)] <= bus.datab[i*WIDTH +: WIDTH];
                end
            end else begin
                for (int j = 0; j < BYTES; j++) begin
                    if (bus.webb[j]) begin
                        mem_q[bus.addrb][j*8 +: 8] <= bus.datab[j*8 +: 8];
                    end
                end
            end
        end else if (r_fire) begin
            for (int i = 0; i < LANES; i++) begin
                mem_q[res_addr + AW'(i)] <= bus.r_data[i*WIDTH +: WIDTH];
            end
        end else if (fin_write) begin
            mem_q[DB_A] <= '0;
        end
    end

`ifdef SCR1_VEC_STREAM_TRACE_EN
    always @(posedge clk) begin
        if (r_fire) begin
            for (int i = 0; i < LANES; i++) begin
                $display("%h", bus.r_data[i*WIDTH +: WIDTH]);
            end
        end
    end
`else
    // Trace disabled: no file I/O.
`endif

    assign bus.qa      = qa_q;
    assign bus.qb      = qb_q;
    assign bus.s_valid = s_valid_q;
    assign bus.s_data  = s_data_q;
    assign bus.r_ready = r_ready_int;
    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.done    = done_q;
    assign dbg_state_o = state_q;
endmodule
